// File: rtl/test_i3966.sv
// s27-style 3-flop Mealy control cell: fixed gate netlist with state {S5,S6,S7}.
// Optional macro TEST_I3966_OUT_REG_EN registers the output (1-cycle latency, resets to 1).
module test_i3966 #(
    parameter logic [2:0] RESET_STATE = 3'b000
) (
    input  logic N0,
    input  logic N1,
    input  logic N2,
    input  logic N3,
    input  logic CK,
    input  logic reset,
    output logic out
);

    // state = {S5, S6, S7}
    logic [2:0] state;
    logic [2:0] state_next;
    logic       s5, s6, s7;
    logic       g8, g9, g10, g11, g12, g13, g14, g15, g16;

    assign s5 = state[2];
    assign s6 = state[1];
    assign s7 = state[0];

    // Gate netlist kept literally so the cell matches its reference netlist.
    assign g14 = ~N0;
    assign g8  = g14 & s6;
    assign g12 = ~(N1 | s7);
    assign g15 = g12 | g8;
    assign g16 = N3 | g8;
    assign g9  = ~(g16 & g15);
    assign g11 = ~(s5 | g9);
    assign g10 = ~(g14 | g11);
    assign g13 = ~(N2 | g12);

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state <= RESET_STATE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = {g10, g11, g13};
    end

`ifdef TEST_I3966_OUT_REG_EN
    logic out_q;

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            out_q <= 1'b1;
        end else begin
            out_q <= ~g11;
        end
    end

    always_comb begin
        out = out_q;
    end
`else
    always_comb begin
        out = ~g11;
    end
`endif

endmodule

// File: tb/tb_test_i3966.sv
// Bench for test_i3966: directed cases plus randomized inputs against a
// reduced-boolean reference model of the cell.
module tb_test_i3966;

    logic N0, N1, N2, N3, CK, reset;
    logic out;

    int tests_run    = 0;
    int tests_failed = 0;

    test_i3966 dut (
        .N0    (N0),
        .N1    (N1),
        .N2    (N2),
        .N3    (N3),
        .CK    (CK),
        .reset (reset),
        .out   (out)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    // Reference model: algebraically reduced form of the cell's equations.
    // n is written N0..N3, so n[3] = N0 and n[0] = N3; st = {S5,S6,S7}.
    function automatic logic model_g11(input logic [2:0] st, input logic [3:0] n);
        logic hold_path, load_path;
        hold_path = !n[3] && st[1];
        load_path = n[0] && !n[2] && !st[0];
        return !st[2] && (hold_path || load_path);
    endfunction

    function automatic logic model_out(input logic [2:0] st, input logic [3:0] n);
        return !model_g11(st, n);
    endfunction

    function automatic logic [2:0] model_next(input logic [2:0] st, input logic [3:0] n);
        logic g11;
        g11 = model_g11(st, n);
        return {n[3] && !g11, g11, !n[1] && (n[2] || st[0])};
    endfunction

    task automatic apply(input logic [3:0] n);
        {N0, N1, N2, N3} = n;
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        apply(4'b0000);
        #2;
        tests_run++;
        if (dut.state !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected 000", dut.state);
        end
        tests_run++;
        if (out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_out: got %b expected 1", out);
        end
        step();
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (dut.state !== 3'b000 || out !== 1'b1) begin
                tests_failed++;
                $display("FAIL idle_hold[%0d]: got state %b out %b expected 000/1", i, dut.state, out);
            end
        end
    endtask

    task automatic test_transitions();
        pulse_reset();
        apply(4'b0001);
        #1;
`ifndef TEST_I3966_OUT_REG_EN
        tests_run++;
        if (out !== 1'b0) begin
            tests_failed++;
            $display("FAIL n3_out: got %b expected 0", out);
        end
`endif
        step();
        tests_run++;
        if (dut.state !== 3'b010) begin
            tests_failed++;
            $display("FAIL n3_next: got %b expected 010", dut.state);
        end

        apply(4'b0000);
        #1;
`ifndef TEST_I3966_OUT_REG_EN
        tests_run++;
        if (out !== 1'b0) begin
            tests_failed++;
            $display("FAIL loop_out: got %b expected 0", out);
        end
`endif
        step();
        tests_run++;
        if (dut.state !== 3'b010) begin
            tests_failed++;
            $display("FAIL loop_next: got %b expected 010", dut.state);
        end

        apply(4'b1000);
        #1;
`ifndef TEST_I3966_OUT_REG_EN
        tests_run++;
        if (out !== 1'b1) begin
            tests_failed++;
            $display("FAIL n0_out: got %b expected 1", out);
        end
`endif
        step();
        tests_run++;
        if (dut.state !== 3'b100) begin
            tests_failed++;
            $display("FAIL n0_next: got %b expected 100", dut.state);
        end

        #1;
        pulse_reset();
        apply(4'b0100);
        #1;
`ifndef TEST_I3966_OUT_REG_EN
        tests_run++;
        if (out !== 1'b1) begin
            tests_failed++;
            $display("FAIL n1_out: got %b expected 1", out);
        end
`endif
        step();
        tests_run++;
        if (dut.state !== 3'b001) begin
            tests_failed++;
            $display("FAIL n1_next: got %b expected 001", dut.state);
        end
    endtask

    task automatic test_async_reset();
        #1;
        pulse_reset();
        apply(4'b0001);
        step();
        tests_run++;
        if (dut.state !== 3'b010) begin
            tests_failed++;
            $display("FAIL areset_setup: got %b expected 010", dut.state);
        end
        apply(4'b0000);
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (dut.state !== 3'b000 || out !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_clear: got state %b out %b expected 000/1", dut.state, out);
        end
        step();
        tests_run++;
        if (dut.state !== 3'b000 || out !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_hold: got state %b out %b expected 000/1", dut.state, out);
        end
        #2;
        reset = 1'b1;
`ifdef TEST_I3966_OUT_REG_EN
        apply(4'b0001);
        #1;
        tests_run++;
        if (out !== 1'b1) begin
            tests_failed++;
            $display("FAIL outreg_lag: got %b expected 1", out);
        end
        step();
        tests_run++;
        if (out !== 1'b0) begin
            tests_failed++;
            $display("FAIL outreg_capture: got %b expected 0", out);
        end
`endif
    endtask

    task automatic test_random();
        logic [2:0] m_state;
        logic       m_out_q;
        logic [3:0] n;
        logic       exp_out;
        #1;
        pulse_reset();
        m_state = 3'b000;
        m_out_q = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n = 4'($urandom_range(0, 15));
            apply(n);
            #1;
`ifdef TEST_I3966_OUT_REG_EN
            exp_out = m_out_q;
`else
            exp_out = model_out(m_state, n);
`endif
            tests_run++;
            if (out !== exp_out) begin
                tests_failed++;
                $display("FAIL rand_out[%0d]: state %b n %b got %b expected %b", i, m_state, n, out, exp_out);
            end
            step();
            m_out_q = model_out(m_state, n);
            m_state = model_next(m_state, n);
            tests_run++;
            if (dut.state !== m_state) begin
                tests_failed++;
                $display("FAIL rand_state[%0d]: n %b got %b expected %b", i, n, dut.state, m_state);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        apply(4'b0000);
        test_reset();
        test_transitions();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
